output_align: RTL and testbench
===============================

// Module: output_align
// PURPOSE
// - Return-path counterpart of the cache input aligner: rebuilds the load result of one possibly line-crossing access.
// - Takes the access descriptor (byte offset, size, split flag, PTC id) plus the line-0 and line-1 read responses.
// - Extracts the addressed bytes, right-justifies them and zero-extends above the access size.
// - Presents the result to the M-stage writeback with a valid/ready handshake. Holds one access in flight.
// PARAMETERS
// - LINE_BYTES  16  bytes per cache line; fixed, offsets are 4 bits
// - OUT_BYTES   8   max access bytes (size 2'b11); out_data = 8*OUT_BYTES bits
// - ID_W        1   width of PTC id carried with the access
// PORTS
// - clk          in   1        single clock, rising edge
// - rst_n        in   1        asynchronous reset, active-low
// - req_valid    in   1        access descriptor valid
// - req_ready    out  1        descriptor accepted this cycle when req_valid&req_ready
// - req_offset   in   4        byte offset of access within line 0 (addr[3:0])
// - req_size     in   2        00=1B 01=2B 10=4B 11=8B
// - req_split    in   1        access crosses into line 1 (line-1 response required)
// - req_id       in   ID_W     PTC id, returned with result
// - rsp0_valid   in   1        line-0 data valid (one-cycle pulse)
// - rsp0_data    in   128      line-0 data, byte k = bits [8k+7:8k]
// - rsp1_valid   in   1        line-1 data valid (one-cycle pulse)
// - rsp1_data    in   128      line-1 data
// - out_valid    out  1        merged result valid
// - out_ready    in   1        consumer takes result when out_valid&out_ready
// - out_data     out  64       right-justified, zero-extended result
// - out_id       out  ID_W     req_id of the access
// - spurious_rsp out  1        one-cycle pulse: response arrived with no slot expecting it (dropped)
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, out_valid=0, out_data=0, out_id=0, spurious_rsp=0; buffers and have0/have1 flags cleared.
// - FSM states IDLE, WAIT, DONE.
//   - IDLE: req_ready=1. On accept, latch offset/size/split/id; need1=split; go WAIT.
//   - WAIT: req_ready=0. rsp0 sets have0 and latches line 0; rsp1 sets have1 and latches line 1 only if need1.
//     When have0 & (have1 | ~need1), go DONE next cycle with out_valid=1 and out_data registered.
//   - DONE: out_valid=1, out_data/out_id stable until handshake.
//     req_ready=out_ready, so back-to-back accesses lose no cycle: on out_ready&req_valid go WAIT with the new descriptor.
//     On out_ready&~req_valid go IDLE.
// - Responses may arrive in the same cycle as the descriptor is accepted; they are captured for that access.
// - rsp0 and rsp1 may arrive in either order or in the same cycle.
// - Latency: last needed response in cycle N gives out_valid=1 in cycle N+1.
// - Merge: n = 1<<req_size bytes.
//   - result byte j (j<n) = line0[offset+j] if offset+j<16, else line1[offset+j-16].
//   - Bytes j>=n are 0. The offset+j sum uses 5-bit arithmetic, no wrap into line 0.
// - Spurious (pulse, response dropped, state unchanged):
//   - rsp0 while have0 is already set;
//   - rsp1 with ~need1 or with have1 already set;
//   - any response in IDLE without a same-cycle accept, or in DONE.
// - req_split=0 with offset+n>16: bytes beyond the line read as 0. The descriptor is the requester's error and is not flagged.
// - rst_n asserted mid-access: the in-flight access is discarded, no output produced; post-reset responses are spurious.
// TESTING
// - off=4, size=10, split=0, rsp0 bytes k=k in cycle after accept
//   -> next cycle out_valid=1, out_data=64'h0000_0000_0706_0504.
// - off=14, size=10, split=1, rsp1 (bytes 0xA0+k) before rsp0 (bytes k)
//   -> out_valid one cycle after rsp0, out_data=64'h0000_0000_A1A0_0F0E.
// - off=9, size=11, split=1, rsp0 & rsp1 in same cycle as accept
//   -> next cycle out_data=64'hA0_0F0E_0D0C_0B0A_09; out_id=req_id.
// - hold out_ready=0 for 3 cycles in DONE -> out_valid/out_data stable, req_ready=0.
//   Then out_ready=1 with new req_valid -> same-cycle accept, next result 1 cycle after its rsp0.
// - rsp1 during split=0 access, and duplicate rsp0 -> spurious_rsp pulses 1 cycle each, out_data unaffected.
// - rst_n low while in WAIT with have0=1 -> out_valid=0 immediately.
//   After release, rsp1 -> spurious_rsp=1, state stays IDLE.

Source files
------------

// File: rtl/output_align_if.sv
// ----------------------------------------------------------------------------
// output_align_if
// Bundles the descriptor, line-response and result handshakes of the load
// return-path aligner.
//
//   req_valid/req_ready        access descriptor handshake
//   req_offset, req_size       byte offset in line 0, access size code
//   req_split, req_id          line-crossing flag, PTC id
//   rsp0_valid/rsp0_data       line-0 read response (single-cycle pulse)
//   rsp1_valid/rsp1_data       line-1 read response (single-cycle pulse)
//   out_valid/out_ready        merged result handshake
//   out_data, out_id           right-justified result, PTC id
//   spurious_rsp               pulse for a dropped, unexpected response
//
// master: the requester / memory side.  slave: the aligner.
// ----------------------------------------------------------------------------
interface output_align_if #(
   parameter int ID_W = 1
);
   logic            req_valid;
   logic            req_ready;
   logic [3:0]      req_offset;
   logic [1:0]      req_size;
   logic            req_split;
   logic [ID_W-1:0] req_id;
   logic            rsp0_valid;
   logic [127:0]    rsp0_data;
   logic            rsp1_valid;
   logic [127:0]    rsp1_data;
   logic            out_valid;
   logic            out_ready;
   logic [63:0]     out_data;
   logic [ID_W-1:0] out_id;
   logic            spurious_rsp;

   modport master (
      output req_valid, req_offset, req_size, req_split, req_id,
      output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, out_ready,
      input  req_ready, out_valid, out_data, out_id, spurious_rsp
   );

   modport slave (
      input  req_valid, req_offset, req_size, req_split, req_id,
      input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data, out_ready,
      output req_ready, out_valid, out_data, out_id, spurious_rsp
   );
endinterface

// File: rtl/output_align.sv
// ----------------------------------------------------------------------------
// output_align
// Rebuilds the load result of one possibly line-crossing access from its
// descriptor and the line-0 / line-1 read responses. The addressed bytes are
// right-justified and zero-extended above the access size, then presented to
// writeback with a valid/ready handshake. One access is held in flight.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    output_align_if.slave (descriptor, responses, result, spurious)
// ----------------------------------------------------------------------------
module output_align #(
   parameter int ID_W = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   output_align_if.slave       bus
);
   localparam int LINE_BYTES = 16;
   localparam int OUT_BYTES  = 8;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t                  state, state_next;
   logic [3:0]              off_q;
   logic [1:0]              size_q;
   logic                    need1_q;
   logic [ID_W-1:0]         id_q;
   logic                    have0_q, have1_q;
   logic [8*LINE_BYTES-1:0] line0_q, line1_q;
   logic [8*OUT_BYTES-1:0]  out_data_q;
   logic [ID_W-1:0]         out_id_q;
   logic                    spurious_q;

   logic                    req_ready_c, accept;
   logic [3:0]              ctx_off;
   logic [1:0]              ctx_size;
   logic                    ctx_need1, ctx_have0, ctx_have1, ctx_active;
   logic [ID_W-1:0]         ctx_id;
   logic                    take0, take1, new_have0, new_have1, complete;
   logic [8*LINE_BYTES-1:0] line0_next, line1_next;
   logic [8*OUT_BYTES-1:0]  merged;

   // Byte j of the result comes from the 5-bit position offset+j: positions
   // 16..22 index into line 1, so there is never a wrap back into line 0.
   function automatic logic [8*OUT_BYTES-1:0] merge_bytes(
      input logic [3:0]              off,
      input logic [1:0]              size,
      input logic [8*LINE_BYTES-1:0] l0,
      input logic [8*LINE_BYTES-1:0] l1
   );
      logic [8*OUT_BYTES-1:0] r;
      logic [4:0]             pos;
      r = '0;
      for (int j = 0; j < OUT_BYTES; j++) begin
         pos = {1'b0, off} + 5'(j);
         if (j < (1 << size)) begin
            r[8*j +: 8] = pos[4] ? l1[{pos[3:0], 3'b000} +: 8]
                                 : l0[{pos[3:0], 3'b000} +: 8];
         end
      end
      return r;
   endfunction

   // The "context" is the access that owns this cycle's responses: a freshly
   // accepted descriptor takes precedence (responses arriving with the accept
   // belong to it), otherwise the registered access while in WAIT. With no
   // context, any response is spurious and dropped. A split=0 access merges
   // against an all-zero line 1 so bytes past the line end read as zero.
   always_comb begin
      req_ready_c = (state == IDLE) || ((state == DONE) && bus.out_ready);
      accept      = bus.req_valid && req_ready_c;

      if (accept) begin
         ctx_off    = bus.req_offset;
         ctx_size   = bus.req_size;
         ctx_need1  = bus.req_split;
         ctx_id     = bus.req_id;
         ctx_have0  = 1'b0;
         ctx_have1  = 1'b0;
         ctx_active = 1'b1;
      end else begin
         ctx_off    = off_q;
         ctx_size   = size_q;
         ctx_need1  = need1_q;
         ctx_id     = id_q;
         ctx_have0  = have0_q;
         ctx_have1  = have1_q;
         ctx_active = (state == WAIT);
      end

      take0      = bus.rsp0_valid && ctx_active && !ctx_have0;
      take1      = bus.rsp1_valid && ctx_active && ctx_need1 && !ctx_have1;
      new_have0  = ctx_have0 || take0;
      new_have1  = ctx_have1 || take1;
      complete   = ctx_active && new_have0 && (new_have1 || !ctx_need1);
      line0_next = take0 ? bus.rsp0_data : line0_q;
      line1_next = take1 ? bus.rsp1_data : line1_q;
      merged     = merge_bytes(ctx_off, ctx_size, line0_next,
                               ctx_need1 ? line1_next : '0);
   end

   // Next-state logic. From DONE with a same-cycle accept the new access goes
   // straight to WAIT (or DONE if its responses arrived with it), so
   // back-to-back accesses lose no cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = complete ? DONE : WAIT;
         WAIT: if (complete) state_next = DONE;
         DONE: begin
            if (bus.out_ready) begin
               if (accept) state_next = complete ? DONE : WAIT;
               else        state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, descriptor, line buffers and registered outputs. The result is
   // captured in the cycle the last needed response arrives, so out_valid
   // rises on the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         off_q      <= '0;
         size_q     <= '0;
         need1_q    <= 1'b0;
         id_q       <= '0;
         have0_q    <= 1'b0;
         have1_q    <= 1'b0;
         line0_q    <= '0;
         line1_q    <= '0;
         out_data_q <= '0;
         out_id_q   <= '0;
         spurious_q <= 1'b0;
      end else begin
         state      <= state_next;
         spurious_q <= (bus.rsp0_valid && !take0) || (bus.rsp1_valid && !take1);
         line0_q    <= line0_next;
         line1_q    <= line1_next;
         if (accept) begin
            off_q   <= bus.req_offset;
            size_q  <= bus.req_size;
            need1_q <= bus.req_split;
            id_q    <= bus.req_id;
         end
         if (ctx_active) begin
            have0_q <= new_have0;
            have1_q <= new_have1;
         end
         if (complete) begin
            out_data_q <= merged;
            out_id_q   <= ctx_id;
         end
      end
   end

   assign bus.req_ready    = req_ready_c;
   assign bus.out_valid    = (state == DONE);
   assign bus.out_data     = out_data_q;
   assign bus.out_id       = out_id_q;
   assign bus.spurious_rsp = spurious_q;
endmodule

// File: tb/tb_output_align.sv
// ----------------------------------------------------------------------------
// tb_output_align
// Directed bench for output_align: a table of descriptors with hand-computed
// results and response orderings, followed by back-pressure, spurious
// response and mid-access reset sequences. Line 0 carries byte k = k and
// line 1 carries byte k = 0xA0+k throughout.
// ----------------------------------------------------------------------------
module tb_output_align;
   logic clk;
   logic rst_n;

   output_align_if #(.ID_W(1)) bus();

   output_align #(.ID_W(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Response ordering: 0 = rsp0 (and rsp1 if split) the cycle after accept,
   // 1 = rsp1 then rsp0, 2 = all responses with the accept, 3 = rsp0 then rsp1.
   typedef struct {
      logic [3:0]  off;
      logic [1:0]  size;
      logic        split;
      logic        id;
      int          mode;
      logic [63:0] exp;
   } vec_t;

   vec_t         vecs[9];
   logic [127:0] line0_pat, line1_pat;
   int           checks = 0;
   int           errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_rsp();
      bus.rsp0_valid = 1'b0;
      bus.rsp1_valid = 1'b0;
      bus.rsp0_data  = line0_pat;
      bus.rsp1_data  = line1_pat;
   endtask

   task automatic drive_req(input logic [3:0] off, input logic [1:0] size,
                            input logic split, input logic id);
      bus.req_valid  = 1'b1;
      bus.req_offset = off;
      bus.req_size   = size;
      bus.req_split  = split;
      bus.req_id     = id;
   endtask

   task automatic handshake(input string name);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check_output({name, "_released"}, 64'(bus.out_valid), 64'd0);
   endtask

   // Runs one table vector; starts and ends just after a falling edge.
   task automatic apply_stimulus(input vec_t v, input int idx);
      string nm;
      nm = $sformatf("vec%0d", idx);
      check_output({nm, "_ready"}, 64'(bus.req_ready), 64'd1);
      drive_req(v.off, v.size, v.split, v.id);
      if (v.mode == 2) begin
         bus.rsp0_valid = 1'b1;
         bus.rsp1_valid = v.split;
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      clear_rsp();
      case (v.mode)
         0: begin
            bus.rsp0_valid = 1'b1;
            bus.rsp1_valid = v.split;
            @(negedge clk);
            clear_rsp();
         end
         1, 3: begin
            check_output({nm, "_wait0"}, 64'(bus.out_valid), 64'd0);
            if (v.mode == 1) bus.rsp1_valid = 1'b1;
            else             bus.rsp0_valid = 1'b1;
            @(negedge clk);
            clear_rsp();
            check_output({nm, "_wait1"}, 64'(bus.out_valid), 64'd0);
            if (v.mode == 1) bus.rsp0_valid = 1'b1;
            else             bus.rsp1_valid = 1'b1;
            @(negedge clk);
            clear_rsp();
         end
         default: ;
      endcase
      check_output({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
      check_output({nm, "_data"}, bus.out_data, v.exp);
      check_output({nm, "_id"}, 64'(bus.out_id), 64'(v.id));
      check_output({nm, "_spurious"}, 64'(bus.spurious_rsp), 64'd0);
      handshake(nm);
   endtask

   initial begin
      for (int k = 0; k < 16; k++) begin
         line0_pat[8*k +: 8] = 8'(k);
         line1_pat[8*k +: 8] = 8'(8'hA0 + k);
      end

      vecs[0] = '{4'd4,  2'b10, 1'b0, 1'b0, 0, 64'h0000_0000_0706_0504};
      vecs[1] = '{4'd14, 2'b10, 1'b1, 1'b1, 1, 64'h0000_0000_A1A0_0F0E};
      vecs[2] = '{4'd9,  2'b11, 1'b1, 1'b1, 2, 64'hA00F_0E0D_0C0B_0A09};
      vecs[3] = '{4'd12, 2'b11, 1'b0, 1'b0, 0, 64'h0000_0000_0F0E_0D0C};
      vecs[4] = '{4'd5,  2'b00, 1'b0, 1'b1, 2, 64'h0000_0000_0000_0005};
      vecs[5] = '{4'd15, 2'b01, 1'b1, 1'b0, 3, 64'h0000_0000_0000_A00F};
      vecs[6] = '{4'd8,  2'b11, 1'b0, 1'b1, 0, 64'h0F0E_0D0C_0B0A_0908};
      vecs[7] = '{4'd15, 2'b11, 1'b1, 1'b0, 0, 64'hA6A5_A4A3_A2A1_A00F};
      vecs[8] = '{4'd3,  2'b01, 1'b0, 1'b1, 2, 64'h0000_0000_0000_0403};

      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_offset = '0;
      bus.req_size   = '0;
      bus.req_split  = 1'b0;
      bus.req_id     = '0;
      bus.out_ready  = 1'b0;
      clear_rsp();

      // Reset state
      repeat (2) @(negedge clk);
      check_output("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_output("rst_out_data", bus.out_data, 64'd0);
      check_output("rst_out_id", 64'(bus.out_id), 64'd0);
      check_output("rst_spurious", 64'(bus.spurious_rsp), 64'd0);
      check_output("rst_req_ready", 64'(bus.req_ready), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);

      // Table-driven vectors
      for (int i = 0; i < 9; i++) apply_stimulus(vecs[i], i);

      // Back-pressure in DONE, then same-cycle accept of the next access
      drive_req(4'd4, 2'b10, 1'b0, 1'b0);
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.rsp0_valid = 1'b1;
      @(negedge clk);
      clear_rsp();
      for (int c = 0; c < 3; c++) begin
         check_output($sformatf("bp%0d_valid", c), 64'(bus.out_valid), 64'd1);
         check_output($sformatf("bp%0d_data", c), bus.out_data, 64'h0000_0000_0706_0504);
         check_output($sformatf("bp%0d_ready", c), 64'(bus.req_ready), 64'd0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      drive_req(4'd0, 2'b11, 1'b0, 1'b1);
      #1;
      check_output("b2b_req_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.req_valid = 1'b0;
      check_output("b2b_wait", 64'(bus.out_valid), 64'd0);
      bus.rsp0_valid = 1'b1;
      @(negedge clk);
      clear_rsp();
      check_output("b2b_valid", 64'(bus.out_valid), 64'd1);
      check_output("b2b_data", bus.out_data, 64'h0706_0504_0302_0100);
      check_output("b2b_id", 64'(bus.out_id), 64'd1);
      handshake("b2b");

      // Spurious rsp1 during a split=0 access
      drive_req(4'd2, 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.rsp1_valid = 1'b1;
      bus.rsp1_data  = {16{8'hEE}};
      @(negedge clk);
      clear_rsp();
      check_output("sp1_pulse", 64'(bus.spurious_rsp), 64'd1);
      check_output("sp1_no_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      check_output("sp1_pulse_end", 64'(bus.spurious_rsp), 64'd0);
      bus.rsp0_valid = 1'b1;
      @(negedge clk);
      clear_rsp();
      check_output("sp1_valid", 64'(bus.out_valid), 64'd1);
      check_output("sp1_data", bus.out_data, 64'h0000_0000_0000_0002);
      handshake("sp1");

      // Duplicate rsp0 (with different data) during a split access
      drive_req(4'd14, 2'b10, 1'b1, 1'b1);
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.rsp0_valid = 1'b1;
      @(negedge clk);
      bus.rsp0_data  = {16{8'hFF}};
      @(negedge clk);
      clear_rsp();
      check_output("dup0_pulse", 64'(bus.spurious_rsp), 64'd1);
      check_output("dup0_no_valid", 64'(bus.out_valid), 64'd0);
      bus.rsp1_valid = 1'b1;
      @(negedge clk);
      clear_rsp();
      check_output("dup0_valid", 64'(bus.out_valid), 64'd1);
      check_output("dup0_pulse_end", 64'(bus.spurious_rsp), 64'd0);
      check_output("dup0_data", bus.out_data, 64'h0000_0000_A1A0_0F0E);

      // Response while in DONE is dropped
      bus.rsp0_valid = 1'b1;
      bus.rsp0_data  = {16{8'h55}};
      @(negedge clk);
      clear_rsp();
      check_output("done_rsp_pulse", 64'(bus.spurious_rsp), 64'd1);
      check_output("done_rsp_data", bus.out_data, 64'h0000_0000_A1A0_0F0E);
      check_output("done_rsp_valid", 64'(bus.out_valid), 64'd1);
      handshake("done_rsp");

      // Reset while in WAIT with have0 set
      drive_req(4'd4, 2'b10, 1'b1, 1'b1);
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.rsp0_valid = 1'b1;
      @(negedge clk);
      clear_rsp();
      rst_n = 1'b0;
      #1;
      check_output("rstw_valid", 64'(bus.out_valid), 64'd0);
      check_output("rstw_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      bus.rsp1_valid = 1'b1;
      @(negedge clk);
      clear_rsp();
      check_output("rstw_spurious", 64'(bus.spurious_rsp), 64'd1);
      check_output("rstw_no_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      check_output("rstw_idle_valid", 64'(bus.out_valid), 64'd0);
      check_output("rstw_idle_ready", 64'(bus.req_ready), 64'd1);

      // Reset while in DONE drops the result at once
      drive_req(4'd4, 2'b10, 1'b0, 1'b1);
      @(negedge clk);
      bus.req_valid  = 1'b0;
      bus.rsp0_valid = 1'b1;
      @(negedge clk);
      clear_rsp();
      check_output("rstd_pre_valid", 64'(bus.out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check_output("rstd_valid", 64'(bus.out_valid), 64'd0);
      check_output("rstd_data", bus.out_data, 64'd0);
      check_output("rstd_id", 64'(bus.out_id), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
